// File: rtl/ram_arbiter_if.sv
// Shared RAM types and the request/RAM bus between two cores and the RAM arbiter.
// The master side drives requests and RAM status; the slave side is the arbiter.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface ram_arbiter_if;
    import cpu_types_pkg::*;

    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    ramstate_t        ramstate;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [1:0]       iwait;
    logic [1:0]       dwait;
    logic [1:0]       gnt_id;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate,
        input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, gnt_id
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate,
        output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, gnt_id
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-core RAM arbiter: data beats instructions, per-class round robin, one grant at a time.
// Define RAM_ARBITER_STARVE_GUARD_EN to let starved instruction requests win after STARVE_LIMIT data grants.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic         CLK,
    input logic         nRST,
    ram_arbiter_if.slave bus
);
    import cpu_types_pkg::*;

    typedef enum logic {IDLE, GRANT} state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_check
        $error("STARVE_LIMIT must be within 1..7");
    end

    state_t     state_reg, state_next;
    logic [1:0] gnt_reg, gnt_next;
    logic       iptr_reg, iptr_next;
    logic       dptr_reg, dptr_next;

    logic [1:0] d_req;
    logic       any_d, any_i;
    logic       instr_first;
    logic [1:0] pick;
    logic       req_live;
    logic       done;

    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store;
    logic [1:0]  iwait_o, dwait_o;

    // Favour the pointed-to core; fall back to the other one when it is idle.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        return req[ptr] ? ptr : ~ptr;
    endfunction

    assign d_req = bus.dREN | bus.dWEN;
    assign any_d = |d_req;
    assign any_i = |bus.iREN;
    assign pick  = (any_d && !(instr_first && any_i)) ? {1'b1, rr_pick(d_req, dptr_reg)}
                                                      : {1'b0, rr_pick(bus.iREN, iptr_reg)};

    assign req_live = gnt_reg[1] ? d_req[gnt_reg[0]] : bus.iREN[gnt_reg[0]];
    assign done     = (state_reg == GRANT) && req_live && (bus.ramstate == ACCESS);

`ifdef RAM_ARBITER_STARVE_GUARD_EN
    logic [2:0] starve_cnt_reg, starve_cnt_next;

    assign instr_first = ({29'd0, starve_cnt_reg} >= STARVE_LIMIT);

    // The boost is consumed by the IDLE selection it influences.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!any_i)
            starve_cnt_next = 3'd0;
        else if (state_reg == IDLE && instr_first)
            starve_cnt_next = 3'd0;
        else if (done && !gnt_reg[1])
            starve_cnt_next = 3'd0;
        else if (done && gnt_reg[1] && starve_cnt_reg != 3'd7)
            starve_cnt_next = starve_cnt_reg + 3'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt_reg <= 3'd0;
        else
            starve_cnt_reg <= starve_cnt_next;
    end
`else
    assign instr_first = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'd0;
            iptr_reg  <= 1'b0;
            dptr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            iptr_reg  <= iptr_next;
            dptr_reg  <= dptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        iptr_next  = iptr_reg;
        dptr_next  = dptr_reg;
        case (state_reg)
            IDLE: begin
                if (any_d || any_i) begin
                    state_next = GRANT;
                    gnt_next   = pick;
                end
            end
            GRANT: begin
                // A withdrawn request aborts without touching the pointers.
                if (!req_live) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = IDLE;
                    if (gnt_reg[1])
                        dptr_next = ~gnt_reg[0];
                    else
                        iptr_next = ~gnt_reg[0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = 32'd0;
        ram_store = 32'd0;
        iwait_o   = 2'b11;
        dwait_o   = 2'b11;
        if (state_reg == GRANT) begin
            if (gnt_reg[1]) begin
                ram_addr = bus.daddr[gnt_reg[0]];
                if (bus.dWEN[gnt_reg[0]]) begin
                    ram_wen   = 1'b1;
                    ram_store = bus.dstore[gnt_reg[0]];
                end else begin
                    ram_ren = 1'b1;
                end
                if (done)
                    dwait_o[gnt_reg[0]] = 1'b0;
            end else begin
                ram_addr = bus.iaddr[gnt_reg[0]];
                ram_ren  = 1'b1;
                if (done)
                    iwait_o[gnt_reg[0]] = 1'b0;
            end
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = iwait_o;
    assign bus.dwait    = dwait_o;
    assign bus.gnt_id   = gnt_reg;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scenario bench for ram_arbiter: expected grants are queued when stimulus is set up
// and popped as the arbiter presents each grant on the RAM port.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ram_arbiter_if bus();

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic        ren;
        logic        wen;
        logic [31:0] store;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic clear_inputs;
        bus.iREN     = 2'b00;
        bus.dREN     = 2'b00;
        bus.dWEN     = 2'b00;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramstate = FREE;
    endtask

    // Leaves nRST released at a falling edge; the next rising edge arbitrates.
    task automatic reset_dut;
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        exp_q.delete();
        bus.iREN = 2'b11;
        bus.dREN = 2'b11;
        bus.iaddr[0] = 32'h0000_0100;
        bus.iaddr[1] = 32'h0000_0104;
        bus.daddr[0] = 32'h0000_1000;
        bus.daddr[1] = 32'h0000_1004;
        bus.ramstate = ACCESS;
        nRST = 1'b0;
        @(negedge CLK); #1;
        n_tests++;
        if (bus.iwait !== 2'b11 || bus.dwait !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_waits: iwait=%b dwait=%b required 11/11", bus.iwait, bus.dwait);
        end
        n_tests++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'd0 || bus.gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ram: ren=%b wen=%b addr=%h gnt=%0d required 0/0/0/0",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.gnt_id);
        end
        exp_q.push_back('{2'd2, 32'h0000_1000, 1'b1, 1'b0, 32'd0});
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK); #1;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.gnt_id !== e.id || bus.ramaddr !== e.addr || bus.ramREN !== e.ren || bus.dwait !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%0d addr=%h ren=%b dwait=%b required %0d/%h/%b/10",
                     bus.gnt_id, bus.ramaddr, bus.ramREN, bus.dwait, e.id, e.addr, e.ren);
        end
        $display("[TB] test_reset: first grant gnt_id=%0d addr=%h", bus.gnt_id, bus.ramaddr);
    endtask

    task automatic test_alternate;
        bit prev_grant;
        int last_cyc;
        clear_inputs();
        exp_q.delete();
        bus.dREN = 2'b11;
        bus.daddr[0] = 32'h0000_2000;
        bus.daddr[1] = 32'h0000_2004;
        bus.ramstate = ACCESS;
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{(k % 2 == 0) ? 2'd2 : 2'd3, (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_2004,
                              1'b1, 1'b0, 32'd0});
        reset_dut();
        prev_grant = 1'b0;
        last_cyc = -1;
        for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
            @(negedge CLK); #1;
            if (bus.ramREN || bus.ramWEN) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus.gnt_id !== e.id || bus.ramaddr !== e.addr ||
                    bus.dwait !== ((e.id == 2'd2) ? 2'b10 : 2'b01) || prev_grant) begin
                    n_fail++;
                    $display("FAIL alternate_grant: cyc=%0d gnt=%0d addr=%h dwait=%b back_to_back=%b required %0d/%h no back-to-back",
                             c, bus.gnt_id, bus.ramaddr, bus.dwait, prev_grant, e.id, e.addr);
                end
                $display("[TB] test_alternate: cyc=%0d gnt_id=%0d addr=%h", c, bus.gnt_id, bus.ramaddr);
                prev_grant = 1'b1;
                last_cyc = c;
            end else begin
                prev_grant = 1'b0;
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || last_cyc != 6) begin
            n_fail++;
            $display("FAIL alternate_timing: pending=%0d last_grant_cyc=%0d required 0/6", exp_q.size(), last_cyc);
        end
    endtask

    task automatic test_write;
        clear_inputs();
        exp_q.delete();
        bus.dREN[0]   = 1'b1;
        bus.dWEN[0]   = 1'b1;
        bus.daddr[0]  = 32'h0000_0040;
        bus.dstore[0] = 32'hDEAD_BEEF;
        bus.ramstate  = BUSY;
        exp_q.push_back('{2'd2, 32'h0000_0040, 1'b0, 1'b1, 32'hDEAD_BEEF});
        reset_dut();
        @(negedge CLK); #1;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.gnt_id !== e.id || bus.ramaddr !== e.addr || bus.ramREN !== e.ren ||
            bus.ramWEN !== e.wen || bus.ramstore !== e.store || bus.dwait !== 2'b11) begin
            n_fail++;
            $display("FAIL write_busy: gnt=%0d addr=%h ren=%b wen=%b store=%h dwait=%b required %0d/%h/%b/%b/%h/11",
                     bus.gnt_id, bus.ramaddr, bus.ramREN, bus.ramWEN, bus.ramstore, bus.dwait,
                     e.id, e.addr, e.ren, e.wen, e.store);
        end
        bus.ramstate = ACCESS;
        #1;
        n_tests++;
        if (bus.dwait !== 2'b10 || bus.ramWEN !== 1'b1 || bus.ramstore !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_access: dwait=%b wen=%b store=%h required 10/1/deadbeef",
                     bus.dwait, bus.ramWEN, bus.ramstore);
        end
        $display("[TB] test_write: addr=%h store=%h dwait=%b", bus.ramaddr, bus.ramstore, bus.dwait);
        @(negedge CLK);
        bus.dREN = 2'b00;
        bus.dWEN = 2'b00;
        #1;
        n_tests++;
        if (bus.dwait !== 2'b11 || bus.ramWEN !== 1'b0 || bus.ramstore !== 32'd0) begin
            n_fail++;
            $display("FAIL write_after: dwait=%b wen=%b store=%h required 11/0/0", bus.dwait, bus.ramWEN, bus.ramstore);
        end
    endtask

    task automatic test_no_preempt;
        clear_inputs();
        exp_q.delete();
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h0000_0100;
        bus.daddr[1] = 32'h0000_0300;
        bus.ramstate = BUSY;
        exp_q.push_back('{2'd0, 32'h0000_0100, 1'b1, 1'b0, 32'd0});
        exp_q.push_back('{2'd3, 32'h0000_0300, 1'b1, 1'b0, 32'd0});
        reset_dut();
        for (int b = 0; b < 3; b++) begin
            @(negedge CLK); #1;
            n_tests++;
            if (bus.gnt_id !== 2'd0 || bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h0000_0100 ||
                bus.iwait !== 2'b11 || bus.dwait !== 2'b11) begin
                n_fail++;
                $display("FAIL no_preempt_busy%0d: gnt=%0d ren=%b addr=%h iwait=%b dwait=%b required 0/1/00000100/11/11",
                         b, bus.gnt_id, bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait);
            end
            $display("[TB] test_no_preempt: busy cycle %0d gnt_id=%0d", b, bus.gnt_id);
            bus.dREN[1] = 1'b1;
        end
        @(negedge CLK);
        bus.ramstate = ACCESS;
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.gnt_id !== e.id || bus.ramaddr !== e.addr || bus.iwait !== 2'b10 || bus.dwait !== 2'b11) begin
            n_fail++;
            $display("FAIL no_preempt_done: gnt=%0d addr=%h iwait=%b dwait=%b required %0d/%h/10/11",
                     bus.gnt_id, bus.ramaddr, bus.iwait, bus.dwait, e.id, e.addr);
        end
        @(negedge CLK);
        bus.iREN = 2'b00;
        #1;
        n_tests++;
        if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) begin
            n_fail++;
            $display("FAIL no_preempt_bubble: ren=%b dwait=%b required 0/11", bus.ramREN, bus.dwait);
        end
        @(negedge CLK); #1;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.gnt_id !== e.id || bus.ramaddr !== e.addr || bus.ramREN !== e.ren || bus.dwait !== 2'b01) begin
            n_fail++;
            $display("FAIL no_preempt_next: gnt=%0d addr=%h ren=%b dwait=%b required %0d/%h/%b/01",
                     bus.gnt_id, bus.ramaddr, bus.ramREN, bus.dwait, e.id, e.addr, e.ren);
        end
        $display("[TB] test_no_preempt: next gnt_id=%0d addr=%h", bus.gnt_id, bus.ramaddr);
    endtask

    task automatic test_abort;
        clear_inputs();
        exp_q.delete();
        bus.dREN[0]  = 1'b1;
        bus.daddr[0] = 32'h0000_0500;
        bus.daddr[1] = 32'h0000_0504;
        bus.ramstate = BUSY;
        reset_dut();
        @(negedge CLK); #1;
        n_tests++;
        if (bus.gnt_id !== 2'd2 || bus.ramREN !== 1'b1 || bus.dwait !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_grant: gnt=%0d ren=%b dwait=%b required 2/1/11", bus.gnt_id, bus.ramREN, bus.dwait);
        end
        @(negedge CLK);
        bus.dREN = 2'b00;
        #1;
        n_tests++;
        if (bus.dwait !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_drop_wait: dwait=%b required 11", bus.dwait);
        end
        @(negedge CLK); #1;
        n_tests++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.dwait !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_idle: ren=%b wen=%b dwait=%b required 0/0/11", bus.ramREN, bus.ramWEN, bus.dwait);
        end
        // Pointer must still favour d0.
        bus.dREN = 2'b11;
        bus.ramstate = ACCESS;
        exp_q.push_back('{2'd2, 32'h0000_0500, 1'b1, 1'b0, 32'd0});
        @(negedge CLK); #1;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.gnt_id !== e.id || bus.ramaddr !== e.addr) begin
            n_fail++;
            $display("FAIL abort_pointer: gnt=%0d addr=%h required %0d/%h", bus.gnt_id, bus.ramaddr, e.id, e.addr);
        end
        $display("[TB] test_abort: regrant gnt_id=%0d addr=%h", bus.gnt_id, bus.ramaddr);
    endtask

    task automatic test_starve;
        logic [1:0] seq [10];
        int         grants;
`ifdef RAM_ARBITER_STARVE_GUARD_EN
        seq = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0};
`else
        seq = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
`endif
        clear_inputs();
        exp_q.delete();
        bus.dREN     = 2'b11;
        bus.iREN     = 2'b01;
        bus.daddr[0] = 32'h0000_0600;
        bus.daddr[1] = 32'h0000_0604;
        bus.iaddr[0] = 32'h0000_0700;
        bus.ramstate = ACCESS;
        for (int k = 0; k < 10; k++)
            exp_q.push_back('{seq[k], (seq[k] == 2'd0) ? 32'h0000_0700 :
                                      (seq[k] == 2'd2) ? 32'h0000_0600 : 32'h0000_0604,
                              1'b1, 1'b0, 32'd0});
        reset_dut();
        grants = 0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge CLK); #1;
            if (bus.ramREN || bus.ramWEN) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus.gnt_id !== e.id || bus.ramaddr !== e.addr ||
                    bus.iwait !== ((e.id == 2'd0) ? 2'b10 : 2'b11)) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d: gnt=%0d addr=%h iwait=%b required %0d/%h/%b",
                             grants, bus.gnt_id, bus.ramaddr, bus.iwait, e.id, e.addr,
                             (e.id == 2'd0) ? 2'b10 : 2'b11);
                end
                $display("[TB] test_starve: grant %0d gnt_id=%0d addr=%h", grants, bus.gnt_id, bus.ramaddr);
                grants++;
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL starve_timeout: pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alternate();
        test_write();
        test_no_preempt();
        test_abort();
        test_starve();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
